// File: rtl/fxp_div_arbiter_if.sv
// Bundle for the shared divider: per-requester request lanes plus one tagged
// response channel. Master drives requests and rsp_ready; slave is the arbiter.
interface fxp_div_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int ID_W   = 2,
  parameter int DATA_W = 16
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*DATA_W-1:0] req_a;
  logic [NREQ*DATA_W-1:0] req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [DATA_W-1:0]      rsp_out;
  logic                   rsp_overflow;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_out, rsp_overflow
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_out, rsp_overflow
  );
endinterface

// File: rtl/fxp_div_arbiter.sv
// Round-robin shared iterative signed fixed-point divider:
// quotient = (a <<< FRAC_W) / b, truncated toward zero, with overflow flag.
module fxp_div_arbiter #(
  parameter int NREQ   = 4,
  parameter int ID_W   = 2,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  fxp_div_arbiter_if.slave    bus,
  output logic                busy,
  output logic [1:0]          dbg_state
);

  // Handshakes: a request transfers on an edge where req_valid[i] & req_ready[i];
  // a response transfers on an edge where rsp_valid & rsp_ready. Once raised,
  // rsp_valid and its payload stay constant until that transfer edge.

  localparam int NIT = DATA_W + FRAC_W;
  localparam int CW  = $clog2(NIT);
  localparam int RW  = DATA_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   id_q;
  logic              sign_neg;
  logic [NIT-1:0]    dvd;
  logic [NIT-1:0]    quo;
  logic [DATA_W-1:0] dvs;
  logic [RW-1:0]     rem;
  logic [CW-1:0]     cnt;

  // Round-robin search starting at ptr
  logic            found;
  logic [ID_W-1:0] win;
  logic [ID_W:0]   idx;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(NREQ)) idx = idx - (ID_W+1)'(NREQ);
      if (!found && bus.req_valid[idx[ID_W-1:0]]) begin
        found = 1'b1;
        win   = idx[ID_W-1:0];
      end
    end
  end

  logic [ID_W:0]   win_inc;
  logic [ID_W-1:0] ptr_nxt;
  logic            accept;

  assign win_inc = {1'b0, win} + 1'b1;
  assign ptr_nxt = (win_inc >= (ID_W+1)'(NREQ)) ? '0 : win_inc[ID_W-1:0];
  assign accept  = (state == IDLE) && found;

  always_comb begin
    bus.req_ready = '0;
    if (accept && rst_n) bus.req_ready[win] = 1'b1;
  end

  // Winner operands and their magnitudes; -2^(N-1) negates to itself, which
  // reads correctly as an unsigned magnitude.
  logic signed [DATA_W-1:0] sel_a, sel_b;
  logic [NIT-1:0]           dvd_s, dvd_mag;
  logic [DATA_W-1:0]        dvs_mag;
  logic                     b_zero;

  assign sel_a   = bus.req_a[int'(win)*DATA_W +: DATA_W];
  assign sel_b   = bus.req_b[int'(win)*DATA_W +: DATA_W];
  assign dvd_s   = NIT'(sel_a) <<< FRAC_W;
  assign dvd_mag = sel_a[DATA_W-1] ? (~dvd_s + 1'b1) : dvd_s;
  assign dvs_mag = sel_b[DATA_W-1] ? (~sel_b + 1'b1) : sel_b;
  assign b_zero  = (sel_b == '0);

  // One restoring step: shift next dividend bit into the partial remainder.
  logic [RW:0] rem_sh, rem_sub, dvs_ext;
  logic        take;

  assign rem_sh  = {rem, dvd[NIT-1]};
  assign dvs_ext = (RW+1)'(dvs);
  assign take    = (rem_sh >= dvs_ext);
  assign rem_sub = rem_sh - dvs_ext;

  logic [NIT-1:0] q_lim;
  logic           q_ovf;

  assign q_lim = sign_neg ? NIT'(2**(DATA_W-1)) : NIT'(2**(DATA_W-1) - 1);
  assign q_ovf = (quo > q_lim);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = b_zero ? RESP : DIV;
      DIV:     if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = RESP;
      RESP:    if (bus.rsp_valid && bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr              <= '0;
      id_q             <= '0;
      sign_neg         <= 1'b0;
      dvd              <= '0;
      quo              <= '0;
      dvs              <= '0;
      rem              <= '0;
      cnt              <= '0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_id       <= '0;
      bus.rsp_out      <= '0;
      bus.rsp_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ptr      <= ptr_nxt;
            id_q     <= win;
            sign_neg <= sel_a[DATA_W-1] ^ sel_b[DATA_W-1];
            dvd      <= dvd_mag;
            dvs      <= dvs_mag;
            quo      <= '0;
            rem      <= '0;
            cnt      <= CW'(NIT - 1);
            if (b_zero) begin
              bus.rsp_valid    <= 1'b1;
              bus.rsp_id       <= win;
              bus.rsp_out      <= '0;
              bus.rsp_overflow <= 1'b1;
            end
          end
        end
        DIV: begin
          rem <= RW'(take ? rem_sub : rem_sh);
          quo <= {quo[NIT-2:0], take};
          dvd <= {dvd[NIT-2:0], 1'b0};
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          bus.rsp_valid    <= 1'b1;
          bus.rsp_id       <= id_q;
          bus.rsp_out      <= DATA_W'(sign_neg ? (~quo + 1'b1) : quo);
          bus.rsp_overflow <= q_ovf;
        end
        RESP: begin
          if (bus.rsp_ready) bus.rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule
